// File: rtl/seq_det_pkg.sv
// Shared defaults for the parametrised serial pattern detector.
// Pattern length, reset-time pattern and match-counter width live here
// so that the top and its counter agree on a single source of defaults.
package seq_det_pkg;

    // Default pattern length in bits (legal range 2..SEQ_DET_MAX_W).
    localparam int unsigned SEQ_DET_PAT_W   = 5;

    // Longest pattern the fill counter and compare path are sized for.
    localparam int unsigned SEQ_DET_MAX_W   = 32;

    // Pattern loaded at reset; MSB is the first bit received.
    localparam logic [SEQ_DET_PAT_W-1:0] SEQ_DET_PAT_RST = 5'b11011;

    // Default width of the optional saturating match counter.
    localparam int unsigned SEQ_DET_CNT_W   = 8;

endpackage : seq_det_pkg

// File: rtl/seq_det_match_cnt.sv
// Purpose: saturating event counter with synchronous clear (match tally).
// Latency: an increment request is visible on cnt one cycle later.
// Backpressure: none; holds at all-ones instead of wrapping, clr beats inc.
module seq_det_match_cnt
    import seq_det_pkg::*;
#(
    parameter int unsigned CNT_W = SEQ_DET_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise step by one unless already saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : seq_det_match_cnt

// File: rtl/seq_detector_param.sv
// Purpose: serial pattern detector, runtime pattern, overlap/non-overlap modes.
// Latency: bit completing a match at edge k -> out high for cycle k+1 only.
// Backpressure: none; bits are taken whenever in_valid is high, cfg_load drops that bit.
//
// Optional feature: define SEQ_DET_MATCH_CNT_EN to build the saturating match
// counter behind match_cnt; otherwise match_cnt is tied to zero.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned      PAT_W   = SEQ_DET_PAT_W,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(SEQ_DET_PAT_RST),
    parameter int unsigned      CNT_W   = SEQ_DET_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in,
    input  logic             overlap,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    // Fill counts 0..PAT_W, so it needs enough bits to hold PAT_W itself.
    localparam int unsigned     FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_ARM = FILL_W'(PAT_W - 1);

    // Only the PAT_W-1 most recent bits are stored: the newest bit of the
    // compare window is the incoming bit itself, and the oldest stored bit
    // would be shifted out before it could ever be compared again.
    logic [PAT_W-2:0] history_q, history_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [FILL_W-1:0] fill_q,   fill_d;
    logic              out_q,    out_d;

    logic [PAT_W-1:0] window;
    logic             hit;

    // Candidate window and match qualification for the bit arriving this edge.
    // Requiring fill >= PAT_W-1 means every compared bit arrived after the last
    // clear, so stale or reset-time history can never produce a match.
    always_comb begin
        window = {history_q, in};
        hit    = in_valid && (fill_q >= FILL_ARM) && (window == pattern_q);
    end

    // Next-state: cfg_load takes precedence and discards the incoming bit;
    // otherwise a valid bit shifts in, and a non-overlapping match restarts fill.
    always_comb begin
        history_d = history_q;
        pattern_d = pattern_q;
        fill_d    = fill_q;
        out_d     = 1'b0;
        if (cfg_load) begin
            pattern_d = cfg_pattern;
            fill_d    = '0;
        end else if (in_valid) begin
            history_d = window[PAT_W-2:0];
            out_d     = hit;
            if (hit && !overlap) begin
                fill_d = '0;
            end else if (fill_q < FILL_MAX) begin
                fill_d = fill_q + FILL_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            history_q <= '0;
            pattern_q <= PAT_RST;
            fill_q    <= '0;
            out_q     <= 1'b0;
        end else begin
            history_q <= history_d;
            pattern_q <= pattern_d;
            fill_q    <= fill_d;
            out_q     <= out_d;
        end
    end

    assign out = out_q;

`ifdef SEQ_DET_MATCH_CNT_EN
    // Tally of pulses on out; a pattern reload restarts the tally.
    seq_det_match_cnt #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cfg_load),
        .inc (out_q),
        .cnt (match_cnt)
    );
`else
    assign match_cnt = '0;
`endif

endmodule : seq_detector_param

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios with literal expectations
// plus a long randomized run, all checked against a queue-based model.
// The counter is built narrow (2 bits) so saturation is reachable quickly.
module tb_seq_detector_param;

    localparam int unsigned PAT_W    = 5;
    localparam int unsigned TB_CNT_W = 2;
    localparam int unsigned CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_bit = 1'b0;
    logic                overlap = 1'b1;
    logic                cfg_load = 1'b0;
    logic [PAT_W-1:0]    cfg_pattern = '0;
    logic                out;
    logic [TB_CNT_W-1:0] match_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    seq_detector_param #(
        .PAT_W   (PAT_W),
        .PAT_RST (5'b11011),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in          (in_bit),
        .overlap     (overlap),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .out         (out),
        .match_cnt   (match_cnt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Keeps the bits received since the last clear (reset, load, or a
    // non-overlapping match), trimmed to the newest PAT_W. A match means the
    // window is full of fresh bits and reads back equal to the pattern.
    bit             mq[$];
    bit [PAT_W-1:0] exp_pat = 5'b11011;
    bit             exp_out = 1'b0;
    int             exp_cnt = 0;
    bit [PAT_W-1:0] packed_win;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            exp_pat = 5'b11011;
            exp_out = 1'b0;
            exp_cnt = 0;
        end else begin
`ifdef SEQ_DET_MATCH_CNT_EN
            if (cfg_load) exp_cnt = 0;
            else if (exp_out && exp_cnt < int'(CNT_MAX)) exp_cnt = exp_cnt + 1;
`endif
            if (cfg_load) begin
                exp_pat = cfg_pattern;
                mq.delete();
                exp_out = 1'b0;
            end else if (in_valid) begin
                mq.push_back(in_bit);
                if (mq.size() > int'(PAT_W)) void'(mq.pop_front());
                packed_win = '0;
                foreach (mq[i]) packed_win = {packed_win[PAT_W-2:0], mq[i]};
                exp_out = (mq.size() == int'(PAT_W)) && (packed_win == exp_pat);
                if (exp_out && !overlap) mq.delete();
            end else begin
                exp_out = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Every cycle, outputs must agree with the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_out", 32'(out), 32'(exp_out));
            chk("cyc_match_cnt", 32'(match_cnt), 32'(exp_cnt));
        end
    end

    // One input cycle; checks out right after the edge against a literal,
    // and pins the model to the same literal.
    task automatic step(input logic v, input logic b, input logic exp_lit);
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
        chk("lit_out", 32'(out), 32'(exp_lit));
        chk("lit_model", 32'(exp_out), 32'(exp_lit));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_cnt", 32'(match_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_stream(input logic [31:0] bits, input logic [31:0] pulses, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], pulses[i]);
    endtask

    function automatic logic [31:0] exp_cnt_lit(input int v);
`ifdef SEQ_DET_MATCH_CNT_EN
        return 32'(v);
`else
        return 32'd0 + 32'(v - v);
`endif
    endfunction

    initial begin
        @(negedge clk);
        do_reset();
        cmp_en = 1'b1;

        // 1: overlapping, 11011011 -> pulses after bits 5 and 8
        overlap = 1'b1;
        run_stream(32'b11011011, 32'b00001001, 8);

        // 2: non-overlapping, same stream -> pulse after bit 5 only
        do_reset();
        overlap = 1'b0;
        run_stream(32'b11011011, 32'b00001000, 8);
        // 11011 twice back to back -> pulses after bits 5 and 10
        do_reset();
        run_stream(32'b1101111011, 32'b0000100001, 10);

        // 3: gaps in in_valid (in held high during gaps to prove it is ignored)
        do_reset();
        overlap = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int g = 0; g < 3; g++) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);

        // 4: all-zero pattern must not match on reset-time zero history
        do_reset();
        cfg_load    = 1'b1;
        cfg_pattern = 5'b00000;
        step(1'b1, 1'b0, 1'b0);
        cfg_load = 1'b0;
        run_stream(32'b00000, 32'b00001, 5);

        // 5: reset mid-stream discards the partial prefix
        do_reset();
        run_stream(32'b1101, 32'b0000, 4);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        run_stream(32'b1011, 32'b0001, 4);

        // 6: counter saturation, overlap, 11011011011011011
        do_reset();
        overlap = 1'b1;
        begin
            logic [16:0] s6;
            logic [16:0] p6;
            s6 = 17'b11011011011011011;
            p6 = 17'b00001001001001001;
            for (int i = 0; i < 17; i++) begin
                step(1'b1, s6[16-i], p6[16-i]);
                if (i == 5)  chk("cnt_1", 32'(match_cnt), exp_cnt_lit(1));
                if (i == 8)  chk("cnt_2", 32'(match_cnt), exp_cnt_lit(2));
                if (i == 11) chk("cnt_3", 32'(match_cnt), exp_cnt_lit(3));
            end
            step(1'b0, 1'b0, 1'b0);
            chk("cnt_sat", 32'(match_cnt), exp_cnt_lit(3));
        end

        // Randomized run against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rst      = ($urandom_range(0, 249) == 0);
            cfg_load = ($urandom_range(0, 79) == 0);
            case ($urandom_range(0, 3))
                0:       cfg_pattern = 5'b00000;
                1:       cfg_pattern = 5'b11111;
                default: cfg_pattern = PAT_W'($urandom);
            endcase
            in_valid = ($urandom_range(0, 3) != 0);
            in_bit   = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) overlap = ~overlap;
            @(negedge clk);
        end
        rst      = 1'b0;
        cfg_load = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_seq_detector_param
